// File: rtl/mul_5x3_accum_if.sv
// Beat/result bundle between the 5x3 multiplier, the frame accumulator and its consumer.
// slave: accumulator side; master: producer/consumer side.
interface mul_5x3_accum_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 3
);
  logic signed [7:0]       s1;
  logic signed [7:0]       s2;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        sample_cnt;

  modport slave (
    input  s1, s2, in_valid, out_ready,
    output in_ready, acc_out, out_valid, sample_cnt
  );

  modport master (
    output s1, s2, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, sample_cnt
  );
endinterface

// File: rtl/mul_5x3_accum.sv
// Frame accumulator: sums s1+s2 over N_SAMPLES beats, holds total on valid/ready.
// Ports: clk, rst_n (async low), clear (sync abort), bus (slave: beats in, frame out).
module mul_5x3_accum #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 12,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  mul_5x3_accum_if.slave   bus
);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_q, out_d;
  logic                    vld_q, vld_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [8:0]       beat;
  logic signed [ACC_W-1:0] sum;
  logic                    take;

  // 9 bits hold any sum of two 8-bit signed products exactly.
  assign beat = {bus.s1[7], bus.s1} + {bus.s2[7], bus.s2};
  assign sum  = acc_q + {{(ACC_W-9){beat[8]}}, beat};

  assign bus.in_ready   = (state_q == ACCUM) && !clear;
  assign take           = bus.in_valid && bus.in_ready;
  assign bus.acc_out    = out_q;
  assign bus.out_valid  = vld_q;
  assign bus.sample_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (clear) begin
      // Abort drops any pending result but keeps acc_out.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (take) begin
            if (cnt_q == LAST) begin
              out_d   = sum;
              vld_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vld_d   = 1'b0;
            state_d = ACCUM;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
